// File: rtl/fetch_unit.sv
// Instruction fetch unit: one fetch/exec pair per instruction, next-PC select on commit.
// Optional macro PC_MISALIGN_TRAP_EN traps misaligned targets instead of clearing next_pc[1:0].
//   state   | meaning
//   S_IDLE  | one cycle after reset release
//   S_FETCH | imem_req high, waiting for imem_ready
//   S_EXEC  | instr held for decode/execute until commit
//   S_TRAP  | misaligned target taken, halted until reset
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc_plus4,
  input  logic        commit,
  input  logic        pcsrc,
  input  logic        jmp,
  input  logic        jr,
  input  logic [31:0] branch_imm,
  input  logic [31:0] jr_target,
  output logic        misalign
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_TRAP  = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_req;
  logic        r_valid;
  logic        r_misalign;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc_raw;
  logic [31:0] w_next_pc;
  logic        w_trap;

  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_next_pc_raw = w_pc_plus4;
    if (jr)
      w_next_pc_raw = jr_target;
    else if (jmp)
      w_next_pc_raw = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    else if (pcsrc)
      w_next_pc_raw = w_pc_plus4 + (branch_imm << 2);
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign w_next_pc = w_next_pc_raw;
  assign w_trap    = |w_next_pc_raw[1:0];
`else
  // Without the trap the low bits are simply cleared, so S_TRAP is never entered.
  assign w_next_pc = w_next_pc_raw & ~32'd3;
  assign w_trap    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= 32'd0;
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ready) begin
            r_instr <= imem_rdata;
            r_state <= S_EXEC;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
          end
        end
        S_EXEC: begin
          if (commit) begin
            r_valid <= 1'b0;
            if (w_trap) begin
              r_state    <= S_TRAP;
              r_misalign <= 1'b1;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= S_FETCH;
              r_req   <= 1'b1;
            end
          end
        end
        S_TRAP: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign pc_plus4    = w_pc_plus4;
  assign misalign    = r_misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default RESET_PC = 0).
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc_plus4;
  logic        commit;
  logic        pcsrc;
  logic        jmp;
  logic        jr;
  logic [31:0] branch_imm;
  logic [31:0] jr_target;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc_plus4    (pc_plus4),
    .commit      (commit),
    .pcsrc       (pcsrc),
    .jmp         (jmp),
    .jr          (jr),
    .branch_imm  (branch_imm),
    .jr_target   (jr_target),
    .misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge in S_FETCH; returns at the next negedge (S_EXEC).
  task automatic fetch_word(input logic [31:0] w);
    imem_ready = 1'b1;
    imem_rdata = w;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
  endtask

  // Called at a negedge in S_EXEC; returns at the next negedge (S_FETCH).
  task automatic commit_op(input logic jr_i, input logic jmp_i, input logic pcsrc_i,
                           input logic [31:0] imm, input logic [31:0] tgt);
    commit     = 1'b1;
    jr         = jr_i;
    jmp        = jmp_i;
    pcsrc      = pcsrc_i;
    branch_imm = imm;
    jr_target  = tgt;
    @(negedge clk);
    commit     = 1'b0;
    jr         = 1'b0;
    jmp        = 1'b0;
    pcsrc      = 1'b0;
    branch_imm = 32'd0;
    jr_target  = 32'd0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", imem_req); end
    checks++; if (instr !== 32'd0) begin errors++; $display("FAIL rst_instr got %h exp 0", instr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", instr_valid); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign got %0b exp 0", misalign); end
    checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
    checks++; if (pc_plus4 !== 32'd4) begin errors++; $display("FAIL rst_pc4 got %h exp 4", pc_plus4); end
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got %0b exp 0", imem_req); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fetch_req got %0b exp 1", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fetch_valid got %0b exp 0", instr_valid); end
  endtask

  task automatic test_first_fetch;
    checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL first_addr got %h exp 0", imem_addr); end
    fetch_word(32'h2008_0005);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %0b exp 1", instr_valid); end
    checks++; if (instr !== 32'h2008_0005) begin errors++; $display("FAIL first_instr got %h exp 20080005", instr); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL exec_req got %0b exp 0", imem_req); end
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ready = 1'b0;
    checks++; if (instr !== 32'h2008_0005) begin errors++; $display("FAIL exec_hold_instr got %h exp 20080005", instr); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL exec_hold_valid got %0b exp 1", instr_valid); end
    commit_op(1'b1, 1'b0, 1'b0, 32'd0, 32'h40);
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL jr40_addr got %h exp 40", imem_addr); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL jr40_req got %0b exp 1", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL jr40_valid got %0b exp 0", instr_valid); end
  endtask

  task automatic test_branch;
    fetch_word(32'd0);
    checks++; if (pc_plus4 !== 32'h44) begin errors++; $display("FAIL br_pc4 got %h exp 44", pc_plus4); end
    commit_op(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd0);
    checks++; if (imem_addr !== 32'h3C) begin errors++; $display("FAIL br_taken got %h exp 3c", imem_addr); end
    fetch_word(32'd0);
    commit_op(1'b1, 1'b0, 1'b0, 32'd0, 32'h40);
    fetch_word(32'd0);
    commit_op(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd0);
    checks++; if (imem_addr !== 32'h44) begin errors++; $display("FAIL br_not_taken got %h exp 44", imem_addr); end
  endtask

  task automatic test_jump;
    fetch_word(32'd0);
    commit_op(1'b1, 1'b0, 1'b0, 32'd0, 32'h1000_0000);
    checks++; if (imem_addr !== 32'h1000_0000) begin errors++; $display("FAIL jr_hi got %h exp 10000000", imem_addr); end
    fetch_word(32'h0800_0010);
    commit_op(1'b1, 1'b1, 1'b0, 32'd0, 32'h200);
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL jr_over_jmp got %h exp 200", imem_addr); end
    fetch_word(32'd0);
    commit_op(1'b1, 1'b0, 1'b0, 32'd0, 32'h1000_0000);
    fetch_word(32'h0800_0010);
    commit_op(1'b0, 1'b1, 1'b1, 32'h100, 32'h200);
    checks++; if (imem_addr !== 32'h1000_0040) begin errors++; $display("FAIL jmp got %h exp 10000040", imem_addr); end
  endtask

  task automatic test_stall;
    imem_ready = 1'b0;
    commit     = 1'b1;
    jr         = 1'b1;
    pcsrc      = 1'b1;
    jr_target  = 32'h999;
    for (int i = 0; i < 5; i++) begin
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stall_req[%0d] got %0b exp 1", i, imem_req); end
      checks++; if (imem_addr !== 32'h1000_0040) begin errors++; $display("FAIL stall_addr[%0d] got %h exp 10000040", i, imem_addr); end
      checks++; if (instr !== 32'h0800_0010) begin errors++; $display("FAIL stall_instr[%0d] got %h exp 08000010", i, instr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stall_valid[%0d] got %0b exp 0", i, instr_valid); end
      @(negedge clk);
    end
    commit    = 1'b0;
    jr        = 1'b0;
    pcsrc     = 1'b0;
    jr_target = 32'd0;
  endtask

  task automatic test_wrap;
    fetch_word(32'd0);
    commit_op(1'b1, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFC);
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h exp fffffffc", imem_addr); end
    fetch_word(32'd0);
    checks++; if (pc_plus4 !== 32'd0) begin errors++; $display("FAIL wrap_pc4 got %h exp 0", pc_plus4); end
    commit_op(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL wrap_next got %h exp 0", imem_addr); end
    fetch_word(32'd0);
    commit_op(1'b0, 1'b0, 1'b1, 32'h4000_0001, 32'd0);
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL shift_discard got %h exp 8", imem_addr); end
  endtask

  task automatic test_reset_exec;
    fetch_word(32'd0);
    commit_op(1'b1, 1'b0, 1'b0, 32'd0, 32'h80);
    checks++; if (imem_addr !== 32'h80) begin errors++; $display("FAIL rx_addr got %h exp 80", imem_addr); end
    fetch_word(32'h1234_5678);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rx_valid got %0b exp 1", instr_valid); end
    imem_ready = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rx_req got %0b exp 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rx_valid0 got %0b exp 0", instr_valid); end
    checks++; if (instr !== 32'd0) begin errors++; $display("FAIL rx_instr got %h exp 0", instr); end
    checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL rx_addr0 got %h exp 0", imem_addr); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rx_misalign got %0b exp 0", misalign); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rx_idle_req got %0b exp 0", imem_req); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rx_fetch_req got %0b exp 1", imem_req); end
    checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL rx_fetch_addr got %h exp 0", imem_addr); end
    checks++; if (instr !== 32'd0) begin errors++; $display("FAIL rx_ready_ignored got %h exp 0", instr); end
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
  endtask

  task automatic test_misalign;
    fetch_word(32'd0);
    commit_op(1'b1, 1'b0, 1'b0, 32'd0, 32'h102);
`ifdef PC_MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL trap_flag[%0d] got %0b exp 1", i, misalign); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL trap_req[%0d] got %0b exp 0", i, imem_req); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL trap_valid[%0d] got %0b exp 0", i, instr_valid); end
      checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL trap_pc[%0d] got %h exp 0", i, imem_addr); end
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL trap_clear got %0b exp 0", misalign); end
    rst_n = 1'b1;
`else
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL align_addr got %h exp 100", imem_addr); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL align_flag got %0b exp 0", misalign); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL align_req got %0b exp 1", imem_req); end
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    commit     = 1'b0;
    pcsrc      = 1'b0;
    jmp        = 1'b0;
    jr         = 1'b0;
    branch_imm = 32'd0;
    jr_target  = 32'd0;
    test_reset;
    test_first_fetch;
    test_branch;
    test_jump;
    test_stall;
    test_wrap;
    test_reset_exec;
    test_misalign;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port imem_req, output, 1 bit: instruction-memory read request.
REQ-005 The block SHALL have port imem_addr, output, 32 bits: fetch address, always equal to the PC.
REQ-006 The block SHALL have port imem_ready, input, 1 bit: the imem_rdata word is valid this cycle.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits: instruction word returned by memory.
REQ-008 The block SHALL have port instr, output, 32 bits: the latched instruction; opcode in [31:26] and function code in [5:0] feed the decode controller.
REQ-009 The block SHALL have port instr_valid, output, 1 bit: instr is held stable for decode and execute.
REQ-010 The block SHALL have port pc_plus4, output, 32 bits: PC+4, used as the jal link value.
REQ-011 The block SHALL have port commit, input, 1 bit: the datapath has completed instr and the control inputs are valid.
REQ-012 The block SHALL have ports pcsrc, jmp and jr, each input, 1 bit: next-PC selects from the decode controller.
REQ-013 The block SHALL have port branch_imm, input, 32 bits: sign-extended branch word offset.
REQ-014 The block SHALL have port jr_target, input, 32 bits: register-file value for jr.
REQ-015 The block SHALL have port misalign, output, 1 bit: misaligned-target trap flag.

Function
REQ-016 The FSM SHALL have states S_IDLE, S_FETCH, S_EXEC and S_TRAP.
REQ-017 S_IDLE SHALL last exactly one cycle after reset release, then move to S_FETCH.
REQ-018 In S_FETCH, imem_req SHALL be 1; when imem_ready=1 (same-cycle response allowed), instr SHALL load imem_rdata and the FSM SHALL move to S_EXEC.
REQ-019 Minimum fetch latency SHALL be 1 cycle; there is no timeout, and S_FETCH holds while imem_ready=0.
REQ-020 In S_EXEC, instr_valid SHALL be 1 and imem_req 0; instr and PC SHALL be held constant until commit=1.
REQ-021 commit, pcsrc, jmp and jr SHALL be ignored outside S_EXEC; imem_ready SHALL be ignored outside S_FETCH.
REQ-022 On commit in S_EXEC, PC SHALL load next_pc and the FSM SHALL return to S_FETCH, giving one instruction per fetch/exec pair with no overlap.
REQ-023 next_pc priority SHALL be:
- jr=1: jr_target;
- else jmp=1: {pc_plus4[31:28], instr[25:0], 2'b00};
- else pcsrc=1: pc_plus4 + (branch_imm << 2);
- else: pc_plus4.
REQ-024 All PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0, and the shifted offset discards bits above 31.

Reset
REQ-025 While rst_n=0, regardless of the current state:
- PC=RESET_PC, state=S_IDLE;
- instr=0, instr_valid=0, imem_req=0, misalign=0.
REQ-026 Reset asserted mid-fetch or mid-exec SHALL abandon the transaction; an imem_ready arriving during or after reset SHALL be ignored until the next S_FETCH.

Configuration
REQ-027 Macro PC_MISALIGN_TRAP_EN SHALL control misaligned-target handling.
REQ-028 With PC_MISALIGN_TRAP_EN defined, a commit with next_pc[1:0]!=0 SHALL:
- leave PC unchanged and enter S_TRAP;
- in S_TRAP, drive misalign=1, imem_req=0, instr_valid=0;
- remain in S_TRAP until reset.
REQ-029 Without PC_MISALIGN_TRAP_EN, next_pc[1:0] SHALL be forced to 2'b00, S_TRAP SHALL be unreachable, and misalign SHALL be tied to 0.

Verification
REQ-030 Reset, then imem_ready=1 on the first S_FETCH cycle with rdata=32'h2008_0005 -> imem_addr=0, then instr_valid=1 and instr=32'h2008_0005 on the next cycle.
REQ-031 In S_EXEC with PC=0x40, commit, pcsrc=1, branch_imm=32'hFFFF_FFFE -> next imem_addr=0x3C; same with pcsrc=0 -> 0x44.
REQ-032 In S_EXEC with PC=0x1000_0000, instr[25:0]=26'h10, jmp=1 and jr=1 with jr_target=0x200 -> jr wins and imem_addr=0x200; with jr=0 -> imem_addr=0x1000_0040.
REQ-033 imem_ready held low for 5 cycles -> imem_req stays 1, imem_addr and instr are unchanged, and instr_valid=0 throughout.
REQ-034 Reset pulse during S_EXEC at PC=0x80 -> all outputs return to reset values and the next fetch address is RESET_PC.
REQ-035 Commit with jr=1 and jr_target=0x102 -> with PC_MISALIGN_TRAP_EN: misalign=1 and imem_req stays 0 until reset; without the macro: imem_addr=0x100.
